// File: rtl/inst_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface inst_fetch_stage_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/inst_fetch_stage.sv
// RV32I fetch stage: PC, credit-limited in-order imem requests, skid FIFO, IF/ID register.
// Define IMM_PREDECODE_EN to register a predecoded immediate-format select in IF/ID.
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    inst_fetch_stage_if.master        imem,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    input  logic                      stall,
    output logic                      if_valid,
    output logic [31:0]               if_inst,
    output logic [31:0]               if_pc,
    output logic [2:0]                if_imm_ctrl
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc;
    logic [31:0]   fifo_inst [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   rpc       [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rpc_wr, rpc_rd;
    logic [CW-1:0] count, outstanding, drop_cnt;

    logic [CW:0]   in_use;
    logic          credit, accept, rsp, drop, live;
    logic          ifid_load, fifo_empty, pop, bypass, push;
    logic [31:0]   rsp_pc, redirect_target;

`ifdef IMM_PREDECODE_EN
    logic [2:0]    fifo_imm [DEPTH];
    logic [2:0]    if_imm;
    logic [2:0]    rsp_imm;

    // Argument is {funct3, opcode}.
    function automatic logic [2:0] predecode(input logic [9:0] f3_op);
        logic [2:0] sel;
        sel = 3'd7;
        case (f3_op[6:0])
            7'b0010011: begin
                if (f3_op[9:7] == 3'b011)
                    sel = 3'd1;
                else if (f3_op[9:7] == 3'b001 || f3_op[9:7] == 3'b101)
                    sel = 3'd2;
                else
                    sel = 3'd0;
            end
            7'b0000011, 7'b1100111: sel = 3'd0;
            7'b0100011:             sel = 3'd3;
            7'b1100011:             sel = 3'd4;
            7'b0110111, 7'b0010111: sel = 3'd5;
            7'b1101111:             sel = 3'd6;
            default:                sel = 3'd7;
        endcase
        return sel;
    endfunction

    assign rsp_imm     = predecode({imem.imem_rsp_data[14:12], imem.imem_rsp_data[6:0]});
    assign if_imm_ctrl = if_imm;
`else
    assign if_imm_ctrl = 3'd7;
`endif

    assign in_use          = {1'b0, count} + {1'b0, outstanding};
    assign credit          = in_use < DEPTH_C;
    assign imem.imem_req_valid = credit & ~rst & ~redirect_valid;
    assign imem.imem_req_addr  = pc;
    assign accept          = imem.imem_req_valid & imem.imem_req_ready;
    assign rsp             = imem.imem_rsp_valid;
    assign drop            = rsp & (drop_cnt != '0);
    assign live            = rsp & ~drop;
    assign ifid_load       = ~stall | ~if_valid;
    assign fifo_empty      = (count == '0);
    assign pop             = ifid_load & ~fifo_empty;
    assign bypass          = ifid_load & fifo_empty & live;
    assign push            = live & ~bypass;
    assign rsp_pc          = rpc[rpc_rd];
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (accept)
            rpc[rpc_wr] <= pc;
        if (push) begin
            fifo_inst[wr_ptr] <= imem.imem_rsp_data;
            fifo_pc[wr_ptr]   <= rsp_pc;
`ifdef IMM_PREDECODE_EN
            fifo_imm[wr_ptr]  <= rsp_imm;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC & 32'hFFFF_FFFC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rpc_wr      <= '0;
            rpc_rd      <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            if_valid    <= 1'b0;
            if_inst     <= NOP;
            if_pc       <= '0;
`ifdef IMM_PREDECODE_EN
            if_imm      <= '0;
`endif
        end else begin
            if (accept)
                rpc_wr <= rpc_wr + AW'(1);
            if (rsp)
                rpc_rd <= rpc_rd + AW'(1);
            if (redirect_valid) begin
                pc          <= redirect_target;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count       <= '0;
                if_valid    <= 1'b0;
                outstanding <= outstanding - CW'(rsp);
                // Every request still in flight after this cycle is stale,
                // including ones already marked for dropping.
                drop_cnt    <= outstanding - CW'(rsp);
            end else begin
                if (accept)
                    pc <= pc + 32'd4;
                outstanding <= outstanding + CW'(accept) - CW'(rsp);
                if (drop)
                    drop_cnt <= drop_cnt - CW'(1);
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (ifid_load) begin
                    if (pop) begin
                        if_valid <= 1'b1;
                        if_inst  <= fifo_inst[rd_ptr];
                        if_pc    <= fifo_pc[rd_ptr];
`ifdef IMM_PREDECODE_EN
                        if_imm   <= fifo_imm[rd_ptr];
`endif
                    end else if (bypass) begin
                        if_valid <= 1'b1;
                        if_inst  <= imem.imem_rsp_data;
                        if_pc    <= rsp_pc;
`ifdef IMM_PREDECODE_EN
                        if_imm   <= rsp_imm;
`endif
                    end else begin
                        if_valid <= 1'b0;
                    end
                end
            end
        end
    end
endmodule
